cr16_control_fsm: RTL and testbench
===================================

CR16_CONTROL_FSM -- requirements
Module: cr16_control_fsm

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning the register count; one-hot enable width equals NUM_REGS.
REQ-002 SHALL have port I_CLK  input  1  sole clock, rising-edge.
REQ-003 SHALL have port I_NRESET  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port I_INSTR  input  16  instruction word.
REQ-005 SHALL have port I_INSTR_VALID  input  1  I_INSTR is valid.
REQ-006 SHALL have port O_INSTR_READY  output  1  block accepts an instruction this cycle.
REQ-007 SHALL have ports O_REG_ENABLE (output, NUM_REGS, one-hot write enable), O_READ_PORT_A_SEL (output, 4) and O_READ_PORT_B_SEL (output, 4), carrying the binary register selects.
REQ-008 SHALL have ports O_IMMEDIATE (output, 16, extended immediate), O_IMM_SEL (output, 1, immediate replaces port B), O_OPCODE (output, 4, ALU operation) and O_ILLEGAL (output, 1, one-cycle pulse on an undecodable word).

Function
REQ-009 SHALL decode the format as [15:12] op, [11:8] Rdest, [7:4] opext or imm-high, [3:0] Rsrc or imm-low.
REQ-010 SHALL accept register forms only when op = 0000, with opext ADD=0101, SUB=1001, CMP=1011, AND=0001, OR=0010, XOR=0011, MOV=1101.
REQ-011 SHALL accept immediate forms when op equals one of those same codes, with imm8 = [7:0].
REQ-012 SHALL sign-extend imm8 for ADD, SUB and CMP, and zero-extend it for AND, OR, XOR and MOV.
REQ-013 SHALL drive A_SEL = Rdest and B_SEL = Rsrc for register forms, and A_SEL = Rdest, B_SEL = 0, IMM_SEL = 1 for immediate forms.
REQ-014 SHALL set O_REG_ENABLE = 1 << Rdest in EXECUTE for every op except CMP, which drives all-zero enable (flags only).
REQ-015 SHALL flag as illegal any other op or opext, and any Rdest or Rsrc >= NUM_REGS.
REQ-016 SHALL implement states FETCH, DECODE, EXECUTE.
REQ-017 In FETCH, O_INSTR_READY = 1; on VALID&&READY the block SHALL capture I_INSTR and go to DECODE, otherwise stay in FETCH.
REQ-018 In DECODE the block SHALL drive selects, immediate, IMM_SEL and OPCODE from the captured word with O_REG_ENABLE = 0, then go to EXECUTE.
REQ-019 In EXECUTE the block SHALL hold the DECODE controls, assert O_REG_ENABLE for exactly one cycle, then return to FETCH.
REQ-020 Illegal words: O_ILLEGAL SHALL pulse in DECODE with all enables 0, and the state SHALL return directly to FETCH.
REQ-021 Latency SHALL be: handshake at cycle N, DECODE at N+1, write enable at N+2, READY again at N+3; throughput is one instruction per 3 cycles.
REQ-022 O_INSTR_READY SHALL be 0 in DECODE and EXECUTE; VALID asserted there SHALL be ignored and the word SHALL NOT be captured.
REQ-023 Controls SHALL return to 0 in FETCH, so no stale write enable is ever issued.

Reset
REQ-024 While I_NRESET = 0 at a rising edge, the state SHALL go to FETCH and all outputs and captured state SHALL clear to 0, except O_INSTR_READY, which SHALL read 1 on the first cycle after release.
REQ-025 Reset in DECODE or EXECUTE SHALL abort the instruction with no O_REG_ENABLE pulse in the following cycle.

Configuration
REQ-026 With CR16_CTRL_INSTR_COUNT_EN defined, the block SHALL add output O_INSTR_COUNT (16 bits), incremented once per legal instruction on leaving EXECUTE, wrapping FFFF->0000, and cleared by reset.
REQ-027 Without CR16_CTRL_INSTR_COUNT_EN, the port and counter SHALL be absent.

Structure
REQ-028 Package cr16_pkg SHALL hold the op/opext code constants, the ALU opcode enum (ADD=4'd1, remaining values owned by the package) and the state typedef.
REQ-029 A combinational sub-module cr16_instr_decoder SHALL map a 16-bit word to controls plus an illegal flag; the FSM instantiates it once on the captured word.

Verification
REQ-030 Reset then ADDI r0,#1 (0x5001): in EXECUTE expect ENABLE=0x0001, IMM=0x0001, IMM_SEL=1, OPCODE=ADD.
REQ-031 ADD r2,r1 (0x0251): expect A_SEL=2, B_SEL=1, IMM_SEL=0, ENABLE=0x0004 at N+2, READY low at N+1 and N+2.
REQ-032 ADDI r3,#-1 (0x53FF) -> IMM=0xFFFF; ANDI r3,#0xFF (0x13FF) -> IMM=0x00FF.
REQ-033 CMP r4,r5 (0x04B5) -> ENABLE stays 0 all cycles; 0xF000 -> ILLEGAL one cycle, next cycle READY=1.
REQ-034 Reset asserted in EXECUTE of 0x5701 -> no ENABLE, outputs 0; back-to-back VALID held -> exactly one capture per 3 cycles; with the macro defined, 0x10000 legal instructions -> count wraps to 0.

Source files
------------

// File: rtl/cr16_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cr16_pkg
// Purpose  : CR16 control codes, ALU opcode enum, FSM state type and helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package cr16_pkg;

   localparam logic [3:0] c_OP_REG    = 4'b0000;
   localparam logic [3:0] c_CODE_ADD  = 4'b0101;
   localparam logic [3:0] c_CODE_SUB  = 4'b1001;
   localparam logic [3:0] c_CODE_CMP  = 4'b1011;
   localparam logic [3:0] c_CODE_AND  = 4'b0001;
   localparam logic [3:0] c_CODE_OR   = 4'b0010;
   localparam logic [3:0] c_CODE_XOR  = 4'b0011;
   localparam logic [3:0] c_CODE_MOV  = 4'b1101;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_SUB = 4'd2,
      ALU_CMP = 4'd3,
      ALU_AND = 4'd4,
      ALU_OR  = 4'd5,
      ALU_XOR = 4'd6,
      ALU_MOV = 4'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2
   } state_e;

   // Shared by register opext and immediate op fields; ALU_NOP marks an unknown code.
   function automatic alu_op_e code_to_alu(input logic [3:0] code);
      case (code)
         c_CODE_ADD: code_to_alu = ALU_ADD;
         c_CODE_SUB: code_to_alu = ALU_SUB;
         c_CODE_CMP: code_to_alu = ALU_CMP;
         c_CODE_AND: code_to_alu = ALU_AND;
         c_CODE_OR:  code_to_alu = ALU_OR;
         c_CODE_XOR: code_to_alu = ALU_XOR;
         c_CODE_MOV: code_to_alu = ALU_MOV;
         default:    code_to_alu = ALU_NOP;
      endcase
   endfunction

   function automatic logic is_signed_imm(input alu_op_e op);
      is_signed_imm = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cr16_instr_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cr16_instr_decoder
// Purpose  : Combinational map from a 16-bit CR16 word to datapath controls.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cr16_instr_decoder
   import cr16_pkg::*;
#(
   parameter int NUM_REGS = 16
)
(
   input  logic [15:0] i_instr,
   output logic [3:0]  o_a_sel,
   output logic [3:0]  o_b_sel,
   output logic [15:0] o_immediate,
   output logic        o_imm_sel,
   output logic [3:0]  o_opcode,
   output logic        o_wr_en,
   output logic        o_illegal
);

   logic [3:0] w_op;
   logic [3:0] w_rdest;
   logic [3:0] w_ext;
   logic [3:0] w_rsrc;
   logic       w_reg_form;
   logic       w_bad;
   alu_op_e    w_alu;

   assign w_op    = i_instr[15:12];
   assign w_rdest = i_instr[11:8];
   assign w_ext   = i_instr[7:4];
   assign w_rsrc  = i_instr[3:0];

   always_comb begin
      w_reg_form  = (w_op == c_OP_REG);
      w_alu       = w_reg_form ? code_to_alu(w_ext) : code_to_alu(w_op);
      // Rsrc only names a register in the register form; otherwise it is imm-low.
      w_bad       = (w_alu == ALU_NOP) ||
                    (int'(w_rdest) >= NUM_REGS) ||
                    (w_reg_form && (int'(w_rsrc) >= NUM_REGS));
      o_a_sel     = '0;
      o_b_sel     = '0;
      o_immediate = '0;
      o_imm_sel   = 1'b0;
      o_opcode    = '0;
      o_wr_en     = 1'b0;
      o_illegal   = w_bad;
      if (!w_bad) begin
         o_a_sel  = w_rdest;
         o_opcode = w_alu;
         o_wr_en  = (w_alu != ALU_CMP);
         if (w_reg_form) begin
            o_b_sel = w_rsrc;
         end else begin
            o_imm_sel   = 1'b1;
            o_immediate = is_signed_imm(w_alu) ? {{8{i_instr[7]}}, i_instr[7:0]}
                                               : {8'h00, i_instr[7:0]};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cr16_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cr16_control_fsm
// Purpose  : FETCH/DECODE/EXECUTE control sequencer for the CR16 datapath.
//            Define CR16_CTRL_INSTR_COUNT_EN to add the O_INSTR_COUNT counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cr16_control_fsm
   import cr16_pkg::*;
#(
   parameter int NUM_REGS = 16
)
(
   input  logic                I_CLK,
   input  logic                I_NRESET,
   input  logic [15:0]         I_INSTR,
   input  logic                I_INSTR_VALID,
   output logic                O_INSTR_READY,
   output logic [NUM_REGS-1:0] O_REG_ENABLE,
   output logic [3:0]          O_READ_PORT_A_SEL,
   output logic [3:0]          O_READ_PORT_B_SEL,
   output logic [15:0]         O_IMMEDIATE,
   output logic                O_IMM_SEL,
   output logic [3:0]          O_OPCODE,
   output logic                O_ILLEGAL
`ifdef CR16_CTRL_INSTR_COUNT_EN
   ,
   output logic [15:0]         O_INSTR_COUNT
`endif
);

   state_e      r_state;
   state_e      w_next;
   logic [15:0] r_instr;

   logic [3:0]  w_a_sel;
   logic [3:0]  w_b_sel;
   logic [15:0] w_immediate;
   logic        w_imm_sel;
   logic [3:0]  w_opcode;
   logic        w_wr_en;
   logic        w_illegal;

   cr16_instr_decoder #(
      .NUM_REGS (NUM_REGS)
   ) u_decoder (
      .i_instr     (r_instr),
      .o_a_sel     (w_a_sel),
      .o_b_sel     (w_b_sel),
      .o_immediate (w_immediate),
      .o_imm_sel   (w_imm_sel),
      .o_opcode    (w_opcode),
      .o_wr_en     (w_wr_en),
      .o_illegal   (w_illegal)
   );

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         r_state <= ST_FETCH;
         r_instr <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_FETCH) && I_INSTR_VALID)
            r_instr <= I_INSTR;
      end
   end

   always_comb begin
      w_next = ST_FETCH;
      case (r_state)
         ST_FETCH:   w_next = I_INSTR_VALID ? ST_DECODE : ST_FETCH;
         ST_DECODE:  w_next = w_illegal ? ST_FETCH : ST_EXECUTE;
         ST_EXECUTE: w_next = ST_FETCH;
         default:    w_next = ST_FETCH;
      endcase
   end

   // Controls are only live in DECODE/EXECUTE; FETCH drives them to zero.
   always_comb begin
      O_INSTR_READY     = 1'b0;
      O_REG_ENABLE      = '0;
      O_READ_PORT_A_SEL = '0;
      O_READ_PORT_B_SEL = '0;
      O_IMMEDIATE       = '0;
      O_IMM_SEL         = 1'b0;
      O_OPCODE          = '0;
      O_ILLEGAL         = 1'b0;
      case (r_state)
         ST_FETCH: begin
            O_INSTR_READY = 1'b1;
         end
         ST_DECODE, ST_EXECUTE: begin
            O_READ_PORT_A_SEL = w_a_sel;
            O_READ_PORT_B_SEL = w_b_sel;
            O_IMMEDIATE       = w_immediate;
            O_IMM_SEL         = w_imm_sel;
            O_OPCODE          = w_opcode;
            if (r_state == ST_DECODE)
               O_ILLEGAL = w_illegal;
            else if (w_wr_en)
               O_REG_ENABLE = NUM_REGS'(1) << w_a_sel;
         end
         default: begin
            O_INSTR_READY = 1'b0;
         end
      endcase
   end

`ifdef CR16_CTRL_INSTR_COUNT_EN
   logic [15:0] r_count;

   // Only legal words reach EXECUTE, so leaving it marks one retired instruction.
   always_ff @(posedge I_CLK) begin
      if (!I_NRESET)
         r_count <= '0;
      else if (r_state == ST_EXECUTE)
         r_count <= r_count + 16'd1;
   end

   assign O_INSTR_COUNT = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr16_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_cr16_control_fsm
// Purpose  : Directed self-checking bench for cr16_control_fsm.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cr16_control_fsm;
   import cr16_pkg::*;

   logic        I_CLK;
   logic        I_NRESET;
   logic [15:0] I_INSTR;
   logic        I_INSTR_VALID;
   logic        O_INSTR_READY;
   logic [15:0] O_REG_ENABLE;
   logic [3:0]  O_READ_PORT_A_SEL;
   logic [3:0]  O_READ_PORT_B_SEL;
   logic [15:0] O_IMMEDIATE;
   logic        O_IMM_SEL;
   logic [3:0]  O_OPCODE;
   logic        O_ILLEGAL;
`ifdef CR16_CTRL_INSTR_COUNT_EN
   logic [15:0] O_INSTR_COUNT;
`endif

   int n_cmp;
   int n_err;

   cr16_control_fsm #(
      .NUM_REGS (16)
   ) dut (
      .I_CLK             (I_CLK),
      .I_NRESET          (I_NRESET),
      .I_INSTR           (I_INSTR),
      .I_INSTR_VALID     (I_INSTR_VALID),
      .O_INSTR_READY     (O_INSTR_READY),
      .O_REG_ENABLE      (O_REG_ENABLE),
      .O_READ_PORT_A_SEL (O_READ_PORT_A_SEL),
      .O_READ_PORT_B_SEL (O_READ_PORT_B_SEL),
      .O_IMMEDIATE       (O_IMMEDIATE),
      .O_IMM_SEL         (O_IMM_SEL),
      .O_OPCODE          (O_OPCODE),
      .O_ILLEGAL         (O_ILLEGAL)
`ifdef CR16_CTRL_INSTR_COUNT_EN
      ,
      .O_INSTR_COUNT     (O_INSTR_COUNT)
`endif
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge I_CLK);
      #1;
   endtask

   // Present a word in FETCH; returns positioned in DECODE with VALID dropped.
   task automatic issue(input logic [15:0] word);
      I_INSTR       = word;
      I_INSTR_VALID = 1'b1;
      step();
      I_INSTR_VALID = 1'b0;
   endtask

   initial begin
      int caps;
      int pulses;
      n_cmp         = 0;
      n_err         = 0;
      I_NRESET      = 1'b0;
      I_INSTR       = 16'h0000;
      I_INSTR_VALID = 1'b0;
      repeat (3) step();
      I_NRESET = 1'b1;
      check_eq("rst_ready",   32'(O_INSTR_READY), 32'd1);
      check_eq("rst_enable",  32'(O_REG_ENABLE),  32'd0);
      check_eq("rst_imm",     32'(O_IMMEDIATE),   32'd0);
      check_eq("rst_illegal", 32'(O_ILLEGAL),     32'd0);
      check_eq("rst_opcode",  32'(O_OPCODE),      32'd0);
`ifdef CR16_CTRL_INSTR_COUNT_EN
      check_eq("rst_count",   32'(O_INSTR_COUNT), 32'd0);
`endif

      // ADDI r0,#1
      issue(16'h5001);
      check_eq("addi_dec_en",    32'(O_REG_ENABLE),  32'd0);
      check_eq("addi_dec_ready", 32'(O_INSTR_READY), 32'd0);
      step();
      check_eq("addi_ex_en",     32'(O_REG_ENABLE),  32'h0001);
      check_eq("addi_ex_imm",    32'(O_IMMEDIATE),   32'h0001);
      check_eq("addi_ex_immsel", 32'(O_IMM_SEL),     32'd1);
      check_eq("addi_ex_op",     32'(O_OPCODE),      32'(ALU_ADD));
      check_eq("addi_ex_bsel",   32'(O_READ_PORT_B_SEL), 32'd0);
      step();
      check_eq("addi_f_ready",   32'(O_INSTR_READY), 32'd1);
      check_eq("addi_f_en",      32'(O_REG_ENABLE),  32'd0);
      check_eq("addi_f_imm",     32'(O_IMMEDIATE),   32'd0);

      // ADD r2,r1; a new word shown during DECODE must not be captured
      issue(16'h0251);
      I_INSTR       = 16'h5F7F;
      I_INSTR_VALID = 1'b1;
      check_eq("add_dec_ready", 32'(O_INSTR_READY),      32'd0);
      check_eq("add_dec_asel",  32'(O_READ_PORT_A_SEL),  32'd2);
      check_eq("add_dec_bsel",  32'(O_READ_PORT_B_SEL),  32'd1);
      check_eq("add_dec_en",    32'(O_REG_ENABLE),       32'd0);
      step();
      I_INSTR_VALID = 1'b0;
      check_eq("add_ex_ready",  32'(O_INSTR_READY),      32'd0);
      check_eq("add_ex_en",     32'(O_REG_ENABLE),       32'h0004);
      check_eq("add_ex_asel",   32'(O_READ_PORT_A_SEL),  32'd2);
      check_eq("add_ex_bsel",   32'(O_READ_PORT_B_SEL),  32'd1);
      check_eq("add_ex_immsel", 32'(O_IMM_SEL),          32'd0);
      step();
      check_eq("add_f_ready",   32'(O_INSTR_READY),      32'd1);

      // ADDI r3,#-1 sign-extends
      issue(16'h53FF);
      step();
      check_eq("addim1_imm", 32'(O_IMMEDIATE),  32'hFFFF);
      check_eq("addim1_en",  32'(O_REG_ENABLE), 32'h0008);
      step();

      // ANDI r3,#0xFF zero-extends
      issue(16'h13FF);
      step();
      check_eq("andi_imm", 32'(O_IMMEDIATE), 32'h00FF);
      check_eq("andi_op",  32'(O_OPCODE),    32'(ALU_AND));
      step();

      // SUBI r6,#0x80 sign-extends negative
      issue(16'h9680);
      step();
      check_eq("subi_imm", 32'(O_IMMEDIATE),  32'hFF80);
      check_eq("subi_op",  32'(O_OPCODE),     32'(ALU_SUB));
      check_eq("subi_en",  32'(O_REG_ENABLE), 32'h0040);
      step();

      // XOR r15,r14 register form
      issue(16'h0F3E);
      step();
      check_eq("xor_en", 32'(O_REG_ENABLE), 32'h8000);
      check_eq("xor_op", 32'(O_OPCODE),     32'(ALU_XOR));
      step();

      // CMP r4,r5: flags only
      issue(16'h04B5);
      check_eq("cmp_dec_en", 32'(O_REG_ENABLE),      32'd0);
      step();
      check_eq("cmp_ex_en",  32'(O_REG_ENABLE),      32'd0);
      check_eq("cmp_ex_op",  32'(O_OPCODE),          32'(ALU_CMP));
      check_eq("cmp_ex_asel",32'(O_READ_PORT_A_SEL), 32'd4);
      step();
      check_eq("cmp_f_en",   32'(O_REG_ENABLE),      32'd0);

      // Illegal op
      issue(16'hF000);
      check_eq("ill_dec_flag", 32'(O_ILLEGAL),     32'd1);
      check_eq("ill_dec_en",   32'(O_REG_ENABLE),  32'd0);
      step();
      check_eq("ill_nxt_ready",32'(O_INSTR_READY), 32'd1);
      check_eq("ill_nxt_flag", 32'(O_ILLEGAL),     32'd0);

      // Illegal opext in register form
      issue(16'h0371);
      check_eq("ill2_flag",  32'(O_ILLEGAL),     32'd1);
      step();
      check_eq("ill2_ready", 32'(O_INSTR_READY), 32'd1);
      check_eq("ill2_en",    32'(O_REG_ENABLE),  32'd0);

      // Reset asserted in EXECUTE of ADDI r7,#1
      issue(16'h5701);
      step();
      check_eq("rstx_ex_en", 32'(O_REG_ENABLE), 32'h0080);
      I_NRESET = 1'b0;
      step();
      check_eq("rstx_en",    32'(O_REG_ENABLE), 32'd0);
      check_eq("rstx_imm",   32'(O_IMMEDIATE),  32'd0);
      check_eq("rstx_op",    32'(O_OPCODE),     32'd0);
      I_NRESET = 1'b1;
      step();
      check_eq("rstx_ready", 32'(O_INSTR_READY), 32'd1);
      check_eq("rstx_en2",   32'(O_REG_ENABLE),  32'd0);
`ifdef CR16_CTRL_INSTR_COUNT_EN
      check_eq("rstx_count", 32'(O_INSTR_COUNT), 32'd0);
`endif

      // Reset asserted in DECODE
      issue(16'h0251);
      I_NRESET = 1'b0;
      step();
      I_NRESET = 1'b1;
      check_eq("rstd_en", 32'(O_REG_ENABLE), 32'd0);
      step();
      check_eq("rstd_en2", 32'(O_REG_ENABLE), 32'd0);

      // VALID held: one capture and one write every 3 cycles
      caps          = 0;
      pulses        = 0;
      I_INSTR       = 16'h5001;
      I_INSTR_VALID = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (O_INSTR_READY) caps++;
         if (O_REG_ENABLE != 16'd0) pulses++;
         step();
      end
      I_INSTR_VALID = 1'b0;
      check_eq("b2b_captures", 32'(caps),   32'd3);
      check_eq("b2b_pulses",   32'(pulses), 32'd3);
`ifdef CR16_CTRL_INSTR_COUNT_EN
      check_eq("b2b_count",    32'(O_INSTR_COUNT), 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
